// File: rtl/regbank_arb_pkg.sv
// Shared definitions for the register-bank write arbiter: FSM state
// encoding, the gap-counter limit and a constant-foldable clog2 helper.
package regbank_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } arb_state_e;

    // Largest idle gap that can be forced after a write.
    localparam int MAX_GAP_CYCLES = 15;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result++;
            rem = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/regbank_write_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. Given a request vector and
// the index of the last winner, returns a one-hot grant and its index for
// the first requester found searching ptr+1, ptr+2, ... with wrap-around.
module rr_pick
    import regbank_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          found
);

    // Walk the requesters in rotating priority order, first valid one wins.
    always_comb begin
        logic [IW-1:0] cand;
        // NOTE: every output gets a default before the loop so no path
        // leaves a value unassigned, which would infer a latch.
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int off = 1; off <= N; off++) begin
            cand = IW'((int'(ptr) + off) % N);
            if (!found && valid[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/regbank_write_arbiter.sv
// regbank_write_arbiter: shares the single write port of a register bank
// between NUM_REQ requesters. Round-robin grant in IDLE, one-cycle ISSUE
// driving a one-hot wr_en plus wr_data, then GAP_CYCLES forced idle cycles.
// Optional feature macro: REGBANK_ZERO_PROTECT_EN makes address 0 a
// hardwired-zero register; writes to it are dropped and flagged sticky on
// err_zero_wr. Without the macro address 0 is ordinary and err_zero_wr = 0.
module regbank_write_arbiter
    import regbank_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int NUM_REGS   = 8,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 3,
    parameter int GAP_CYCLES = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REGS-1:0]         wr_en,
    output logic [DATA_W-1:0]           wr_data,
    output logic [clog2(NUM_REQ)-1:0]   grant_id,
    output logic                        busy,
    output logic                        err_zero_wr
);

    localparam int ID_W     = clog2(NUM_REQ);
    localparam int GAP_W    = clog2(MAX_GAP_CYCLES + 1);
    localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

`ifdef REGBANK_ZERO_PROTECT_EN
    localparam bit ZERO_PROTECT = 1'b1;
`else
    localparam bit ZERO_PROTECT = 1'b0;
`endif

    if (NUM_REQ < 2 || NUM_REQ > 8 || NUM_REGS < 2 || NUM_REGS > 32 ||
        GAP_CYCLES < 0 || GAP_CYCLES > MAX_GAP_CYCLES ||
        (1 << ADDR_W) < NUM_REGS) begin : g_bad_params
        $error("regbank_write_arbiter: illegal parameter combination");
    end

    arb_state_e          state;
    logic [ID_W-1:0]     ptr;
    logic [GAP_W-1:0]    gap_cnt;
    logic                err_q;

    logic [NUM_REQ-1:0]  pick_grant;
    logic [ID_W-1:0]     pick_idx;
    logic                pick_found;

    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;
    logic [NUM_REGS-1:0] wr_en_next;
    logic                zero_hit;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_rr_pick (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Route the winning requester's address and data.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Decode the winner's address; out-of-range (and protected zero) give no enable.
    always_comb begin
        wr_en_next = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            wr_en_next[r] = (sel_addr == ADDR_W'(r));
        end
        zero_hit = (sel_addr == '0);
        if (ZERO_PROTECT) begin
            wr_en_next[0] = 1'b0;
        end
    end

    assign req_ready   = (state == IDLE) ? pick_grant : '0;
    assign busy        = (state != IDLE);
    assign err_zero_wr = ZERO_PROTECT ? err_q : 1'b0;

    // Arbiter FSM with registered write-port outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= ID_W'(NUM_REQ - 1);
            gap_cnt  <= '0;
            wr_en    <= '0;
            wr_data  <= '0;
            grant_id <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_en <= '0;
            unique case (state)
                IDLE: begin
                    if (pick_found) begin
                        wr_en    <= wr_en_next;
                        if (|wr_en_next) begin
                            wr_data <= sel_data;
                        end
                        grant_id <= pick_idx;
                        ptr      <= pick_idx;
                        state    <= ISSUE;
                        if (ZERO_PROTECT && zero_hit) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (GAP_CYCLES > 0) begin
                        gap_cnt <= GAP_W'(GAP_LOAD);
                        state   <= GAP;
                    end else begin
                        state <= IDLE;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Self-checking bench for regbank_write_arbiter. Two instances run side by
// side: A (6 registers, no gap, exercises out-of-range addresses) and
// B (8 registers, 3-cycle gap). A transaction-level model predicts, per
// cycle, which requester is granted, when the write pulse appears and how
// long the arbiter stays unavailable afterwards.
module tb_regbank_write_arbiter;
    import regbank_arb_pkg::*;

    localparam int NR = 4;
    localparam int AW = 3;
    localparam int DW = 32;
    localparam int NI = 2;

`ifdef REGBANK_ZERO_PROTECT_EN
    localparam bit ZP = 1'b1;
`else
    localparam bit ZP = 1'b0;
`endif

    logic clk;
    logic rst_n;

    logic [NR-1:0]    valid [NI];
    logic [AW-1:0]    addr  [NI][NR];
    logic [DW-1:0]    data  [NI][NR];
    logic [NR*AW-1:0] addr_p [NI];
    logic [NR*DW-1:0] data_p [NI];

    logic [NR-1:0]    ready_o   [NI];
    logic [7:0]       wr_en_o   [NI];
    logic [DW-1:0]    wr_data_o [NI];
    logic [1:0]       gid_o     [NI];
    logic             busy_o    [NI];
    logic             err_o     [NI];
    logic [5:0]       wr_en_a;
    logic [7:0]       wr_en_b;

    for (genvar k = 0; k < NI; k++) begin : g_pack
        for (genvar i = 0; i < NR; i++) begin : g_req
            assign addr_p[k][i*AW +: AW] = addr[k][i];
            assign data_p[k][i*DW +: DW] = data[k][i];
        end
    end
    assign wr_en_o[0] = {2'b00, wr_en_a};
    assign wr_en_o[1] = wr_en_b;

    regbank_write_arbiter #(
        .NUM_REQ(NR), .NUM_REGS(6), .DATA_W(DW), .ADDR_W(AW), .GAP_CYCLES(0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(valid[0]), .req_addr(addr_p[0]), .req_data(data_p[0]),
        .req_ready(ready_o[0]), .wr_en(wr_en_a), .wr_data(wr_data_o[0]),
        .grant_id(gid_o[0]), .busy(busy_o[0]), .err_zero_wr(err_o[0])
    );

    regbank_write_arbiter #(
        .NUM_REQ(NR), .NUM_REGS(8), .DATA_W(DW), .ADDR_W(AW), .GAP_CYCLES(3)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(valid[1]), .req_addr(addr_p[1]), .req_data(data_p[1]),
        .req_ready(ready_o[1]), .wr_en(wr_en_b), .wr_data(wr_data_o[1]),
        .grant_id(gid_o[1]), .busy(busy_o[1]), .err_zero_wr(err_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Model state: last winner, cycles the port remains unavailable, and
    // the outputs expected in the current cycle.
    int          m_last [NI];
    int          m_hold [NI];
    int          m_gid  [NI];
    logic [7:0]  m_wr_en   [NI];
    logic [31:0] m_wr_data [NI];
    bit          m_err  [NI];
    logic [NR-1:0] m_acc [NI];

    function automatic int regs_of(input int k);
        return (k == 0) ? 6 : 8;
    endfunction

    function automatic int gap_of(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    function automatic string name_of(input int k);
        return (k == 0) ? "A" : "B";
    endfunction

    // Requester that the rotating-priority rule selects, or -1 if none.
    function automatic int winner(input int k);
        for (int off = 1; off <= NR; off++) begin
            int c;
            c = (m_last[k] + off) % NR;
            if (valid[k][c]) return c;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            m_last[k]    = NR - 1;
            m_hold[k]    = 0;
            m_gid[k]     = 0;
            m_wr_en[k]   = '0;
            m_wr_data[k] = '0;
            m_err[k]     = 1'b0;
            m_acc[k]     = '0;
        end
    endtask

    task automatic new_req(input int k, input int i);
        valid[k][i] = 1'b1;
        addr[k][i]  = AW'($urandom_range(0, 7));
        data[k][i]  = $urandom;
    endtask

    // Modes: 0 all idle, 1 only retire granted requests,
    // 2 every requester continuously valid, 3 random traffic.
    task automatic drive_phase(input int mode);
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < NR; i++) begin
                if (m_acc[k][i]) begin
                    valid[k][i] = 1'b0;
                    if (mode == 2 || (mode == 3 && $urandom_range(0, 1) == 1)) new_req(k, i);
                end else if (mode == 0) begin
                    valid[k][i] = 1'b0;
                end else if (mode == 2) begin
                    if (!valid[k][i]) new_req(k, i);
                end else if (mode == 3) begin
                    if (valid[k][i]) begin
                        if ($urandom_range(0, 15) == 0) valid[k][i] = 1'b0;
                    end else if ($urandom_range(0, 2) == 0) begin
                        new_req(k, i);
                    end
                end
            end
        end
    endtask

    // Compare all outputs mid-cycle, then advance the model across the next edge.
    task automatic check_phase();
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            int w;
            logic [NR-1:0] exp_ready;
            string nm;
            nm = name_of(k);
            w  = winner(k);
            exp_ready = '0;
            if (m_hold[k] == 0 && w >= 0) exp_ready[w] = 1'b1;
            check($sformatf("%s.ready@%0d", nm, cyc), 32'(ready_o[k]), 32'(exp_ready));
            check($sformatf("%s.wr_en@%0d", nm, cyc), 32'(wr_en_o[k]), 32'(m_wr_en[k]));
            check($sformatf("%s.wr_data@%0d", nm, cyc), wr_data_o[k], m_wr_data[k]);
            check($sformatf("%s.grant_id@%0d", nm, cyc), 32'(gid_o[k]), 32'(m_gid[k]));
            check($sformatf("%s.busy@%0d", nm, cyc), 32'(busy_o[k]), 32'(m_hold[k] > 0));
            check($sformatf("%s.err@%0d", nm, cyc), 32'(err_o[k]), 32'(m_err[k]));

            m_acc[k] = '0;
            if (m_hold[k] == 0 && w >= 0) begin
                int  a;
                bit  eff;
                a   = int'(addr[k][w]);
                eff = (a < regs_of(k));
                if (ZP && a == 0) begin
                    eff      = 1'b0;
                    m_err[k] = 1'b1;
                end
                m_wr_en[k] = eff ? 8'(1 << a) : 8'h00;
                if (eff) m_wr_data[k] = data[k][w];
                m_gid[k]   = w;
                m_last[k]  = w;
                m_hold[k]  = 1 + gap_of(k);
                m_acc[k][w] = 1'b1;
            end else begin
                m_wr_en[k] = '0;
                if (m_hold[k] > 0) m_hold[k]--;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < NI; k++) begin
            valid[k] = '0;
            for (int i = 0; i < NR; i++) begin
                addr[k][i] = '0;
                data[k][i] = '0;
            end
        end
        model_reset();

        // Reset values while rst_n is held low.
        repeat (2) check_phase();
        rst_n = 1'b1;

        // Single request from requester 0 to register 3.
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < NI; k++) begin
            valid[k]   = 4'b0001;
            addr[k][0] = 3'd3;
            data[k][0] = 32'hDEAD_BEEF;
        end
        check_phase();
        repeat (6) begin
            drive_phase(1);
            check_phase();
        end

        // Explicit write to address 0 on both instances.
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < NI; k++) begin
            valid[k]   = 4'b0010;
            addr[k][1] = 3'd0;
            data[k][1] = 32'h0000_1234;
        end
        check_phase();
        repeat (6) begin
            drive_phase(1);
            check_phase();
        end

        // All requesters continuously valid: strict rotation.
        repeat (40) begin
            drive_phase(2);
            check_phase();
        end

        // Random traffic with withdrawals and out-of-range addresses.
        repeat (600) begin
            drive_phase(3);
            check_phase();
        end

        // Drain, then reset while both instances are in ISSUE.
        repeat (8) begin
            drive_phase(0);
            check_phase();
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < NI; k++) begin
            valid[k]   = 4'b0100;
            addr[k][2] = 3'd5;
            data[k][2] = 32'h5A5A_0F0F;
        end
        check_phase();
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("%s.pre_rst_wr_en", name_of(k)), 32'(wr_en_o[k]), 32'(m_wr_en[k]));
        end
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("%s.rst_wr_en", name_of(k)), 32'(wr_en_o[k]), 32'h0);
            check($sformatf("%s.rst_busy", name_of(k)), 32'(busy_o[k]), 32'h0);
            check($sformatf("%s.rst_wr_data", name_of(k)), wr_data_o[k], 32'h0);
            check($sformatf("%s.rst_grant_id", name_of(k)), 32'(gid_o[k]), 32'h0);
        end
        model_reset();
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < NR; i++) new_req(k, i);
        end
        #1;
        rst_n = 1'b1;
        check_phase();
        for (int k = 0; k < NI; k++) begin
            check($sformatf("%s.first_after_rst", name_of(k)), 32'(ready_o[k]), 32'h1);
        end
        repeat (20) begin
            drive_phase(2);
            check_phase();
        end
        repeat (300) begin
            drive_phase(3);
            check_phase();
        end
        repeat (8) begin
            drive_phase(0);
            check_phase();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
